// File: rtl/bram_rmw_counter_ctrl.sv
// Read-modify-write controller keeping one saturating counter per BRAM address.
// Port 1 reads operands, port 2 writes results back; the whole RAM is zeroed after reset.
module bram_rmw_counter_ctrl #(
    parameter int ADDR_BITS   = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int DELTA_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   s_upd_valid,
    output logic                   s_upd_ready,
    input  logic [ADDR_BITS-1:0]   s_upd_addr,
    input  logic [DELTA_WIDTH-1:0] s_upd_delta,
    input  logic                   s_upd_sub,

    input  logic                   s_rd_valid,
    output logic                   s_rd_ready,
    input  logic [ADDR_BITS-1:0]   s_rd_addr,

    output logic                   m_rd_valid,
    output logic [DATA_WIDTH-1:0]  m_rd_data,

    output logic                   init_done,

    output logic                   ram_en1,
    output logic [ADDR_BITS-1:0]   ram_addr1,
    input  logic [DATA_WIDTH-1:0]  ram_dout1,

    output logic                   ram_en2,
    output logic                   ram_we2,
    output logic [ADDR_BITS-1:0]   ram_addr2,
    output logic [DATA_WIDTH-1:0]  ram_din2
);

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    typedef struct packed {
        logic                   valid;
        logic                   is_upd;
        logic                   sub;
        logic [ADDR_BITS-1:0]   addr;
        logic [DELTA_WIDTH-1:0] delta;
    } stage1_t;

    state_t                 state;
    logic [ADDR_BITS-1:0]   clr_addr;
    logic                   prio_rd;

    stage1_t                p1;
    stage1_t                p1_nxt;

    logic                   fwd_valid;
    logic [ADDR_BITS-1:0]   fwd_addr;
    logic [DATA_WIDTH-1:0]  fwd_data;

    logic                   run;
    logic                   clearing;
    logic                   upd_grant;
    logic                   rd_grant;
    logic                   upd_commit;
    logic [DATA_WIDTH-1:0]  old_val;
    logic [DATA_WIDTH-1:0]  delta_ext;
    logic [DATA_WIDTH:0]    sum;
    logic [DATA_WIDTH-1:0]  new_val;

    assign run      = (state == S_RUN);
    // rst gates the sweep write so the RAM port is quiet while reset is held.
    assign clearing = (state == S_CLEAR) && !rst;

    // Contested cycles alternate; prio_rd resets to 0 so updates win the first contest.
    assign upd_grant = run && s_upd_valid && (!s_rd_valid || !prio_rd);
    assign rd_grant  = run && s_rd_valid  && (!s_upd_valid ||  prio_rd);

    assign s_upd_ready = upd_grant;
    assign s_rd_ready  = rd_grant;

    assign ram_en1   = upd_grant || rd_grant;
    assign ram_addr1 = upd_grant ? s_upd_addr : (rd_grant ? s_rd_addr : '0);

    assign upd_commit = p1.valid && p1.is_upd;

    // A read issued in the same cycle as a write to that address returned stale data.
    assign old_val = (fwd_valid && (fwd_addr == p1.addr)) ? fwd_data : ram_dout1;

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        delta_ext                    = '0;
        delta_ext[DELTA_WIDTH-1:0]   = p1.delta;
        sum                          = {1'b0, old_val} + {1'b0, delta_ext};
        new_val                      = '0;
        if (p1.sub) begin
            if (old_val > delta_ext) begin
                new_val = old_val - delta_ext;
            end
        end else begin
            new_val = sum[DATA_WIDTH] ? '1 : sum[DATA_WIDTH-1:0];
        end
    end

    always_comb begin
        ram_we2   = 1'b0;
        ram_addr2 = '0;
        ram_din2  = '0;
        if (clearing) begin
            ram_we2   = 1'b1;
            ram_addr2 = clr_addr;
        end else if (upd_commit) begin
            ram_we2   = 1'b1;
            ram_addr2 = p1.addr;
            ram_din2  = new_val;
        end
    end

    assign ram_en2 = ram_we2;

    assign m_rd_valid = p1.valid && !p1.is_upd;
    assign m_rd_data  = m_rd_valid ? old_val : '0;

    always_comb begin
        p1_nxt        = '0;
        p1_nxt.valid  = upd_grant || rd_grant;
        p1_nxt.is_upd = upd_grant;
        p1_nxt.sub    = s_upd_sub;
        p1_nxt.addr   = upd_grant ? s_upd_addr : s_rd_addr;
        p1_nxt.delta  = s_upd_delta;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_CLEAR;
            clr_addr  <= '0;
            init_done <= 1'b0;
            prio_rd   <= 1'b0;
        end else begin
            case (state)
                S_CLEAR: begin
                    if (clr_addr == '1) begin
                        state     <= S_RUN;
                        init_done <= 1'b1;
                    end else begin
                        clr_addr <= clr_addr + 1'b1;
                    end
                end
                S_RUN: begin
                    if (s_upd_valid && s_rd_valid) begin
                        prio_rd <= ~prio_rd;
                    end
                end
                default: state <= S_CLEAR;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p1        <= '0;
            fwd_valid <= 1'b0;
            fwd_addr  <= '0;
            fwd_data  <= '0;
        end else begin
            p1        <= p1_nxt;
            fwd_valid <= ram_we2;
            fwd_addr  <= ram_addr2;
            fwd_data  <= ram_din2;
        end
    end

endmodule

// File: tb/tb_bram_rmw_counter_ctrl.sv
// Bench for bram_rmw_counter_ctrl: read-first BRAM model plus a per-address counter
// reference model that tracks the expected value of every query in acceptance order.
module tb_bram_rmw_counter_ctrl;

    localparam int AW    = 8;
    localparam int DW    = 32;
    localparam int LW    = 16;
    localparam int DEPTH = 256;
    localparam longint MAXV = 64'h0000_0000_FFFF_FFFF;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_upd_valid = 1'b0;
    logic          s_upd_ready;
    logic [AW-1:0] s_upd_addr = '0;
    logic [LW-1:0] s_upd_delta = '0;
    logic          s_upd_sub = 1'b0;
    logic          s_rd_valid = 1'b0;
    logic          s_rd_ready;
    logic [AW-1:0] s_rd_addr = '0;
    logic          m_rd_valid;
    logic [DW-1:0] m_rd_data;
    logic          init_done;
    logic          ram_en1;
    logic [AW-1:0] ram_addr1;
    logic [DW-1:0] ram_dout1;
    logic          ram_en2;
    logic          ram_we2;
    logic [AW-1:0] ram_addr2;
    logic [DW-1:0] ram_din2;

    always #5 clk = ~clk;

    bram_rmw_counter_ctrl #(.ADDR_BITS(AW), .DATA_WIDTH(DW), .DELTA_WIDTH(LW)) dut (
        .clk(clk), .rst(rst),
        .s_upd_valid(s_upd_valid), .s_upd_ready(s_upd_ready), .s_upd_addr(s_upd_addr),
        .s_upd_delta(s_upd_delta), .s_upd_sub(s_upd_sub),
        .s_rd_valid(s_rd_valid), .s_rd_ready(s_rd_ready), .s_rd_addr(s_rd_addr),
        .m_rd_valid(m_rd_valid), .m_rd_data(m_rd_data), .init_done(init_done),
        .ram_en1(ram_en1), .ram_addr1(ram_addr1), .ram_dout1(ram_dout1),
        .ram_en2(ram_en2), .ram_we2(ram_we2), .ram_addr2(ram_addr2), .ram_din2(ram_din2)
    );

    // True dual-port read-first BRAM with a backdoor write port for presetting counters.
    logic [DW-1:0] mem [DEPTH];
    logic          poke_en = 1'b0;
    logic [AW-1:0] poke_addr = '0;
    logic [DW-1:0] poke_data = '0;

    always @(posedge clk) begin
        if (ram_en1) ram_dout1 <= mem[ram_addr1];
        if (poke_en) mem[poke_addr] <= poke_data;
        else if (ram_we2) mem[ram_addr2] <= ram_din2;
    end

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] model_cnt [DEPTH];
    logic          acc_u, acc_r;
    logic          obs_rv;
    logic [DW-1:0] obs_rd;
    logic          cur_exp_rv, nxt_exp_rv;
    logic [DW-1:0] cur_exp_rd, nxt_exp_rd;

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model_cnt[i] = '0;
        nxt_exp_rv = 1'b0;
        nxt_exp_rd = '0;
    endtask

    task automatic model_update(input logic [AW-1:0] a, input logic [LW-1:0] d, input logic s);
        longint v;
        v = s ? longint'(model_cnt[a]) - longint'(d) : longint'(model_cnt[a]) + longint'(d);
        if (v < 0) v = 0;
        if (v > MAXV) v = MAXV;
        model_cnt[a] = DW'(v);
    endtask

    // One clock of stimulus: samples the result strobe from the previous accept, applies
    // new inputs, and records which stream the DUT accepted this cycle.
    task automatic drive(input logic uv, input logic [AW-1:0] ua, input logic [LW-1:0] ud,
                         input logic us, input logic rv, input logic [AW-1:0] ra);
        @(negedge clk);
        obs_rv     = m_rd_valid;
        obs_rd     = m_rd_data;
        cur_exp_rv = nxt_exp_rv;
        cur_exp_rd = nxt_exp_rd;
        s_upd_valid = uv; s_upd_addr = ua; s_upd_delta = ud; s_upd_sub = us;
        s_rd_valid  = rv; s_rd_addr  = ra;
        #1;
        acc_u = uv && s_upd_ready;
        acc_r = rv && s_rd_ready;
        nxt_exp_rv = acc_r;
        nxt_exp_rd = model_cnt[ra];
        if (acc_u) model_update(ua, ud, us);
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, 1'b0, 1'b0, '0);
    endtask

    task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] v);
        @(negedge clk);
        poke_en = 1'b1; poke_addr = a; poke_data = v;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    task automatic run_clear_check(input string name);
        int writes = 0;
        #1;
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (ram_we2 !== 1'b1 || ram_en2 !== 1'b1 || ram_addr2 !== AW'(i) || ram_din2 !== '0 ||
                init_done !== 1'b0 || ram_en1 !== 1'b0) begin
                errors++;
                $display("FAIL %s sweep %0d: we2=%0b en2=%0b addr2=%0d din2=%h init=%0b en1=%0b, expected 1 1 %0d 0 0 0",
                         name, i, ram_we2, ram_en2, ram_addr2, ram_din2, init_done, ram_en1, i);
            end
            if (ram_we2 === 1'b1) writes++;
            @(negedge clk);
            #1;
        end
        checks++;
        if (init_done !== 1'b1 || ram_we2 !== 1'b0 || writes != DEPTH) begin
            errors++;
            $display("FAIL %s end: init_done=%0b we2=%0b writes=%0d, expected 1 0 %0d",
                     name, init_done, ram_we2, writes, DEPTH);
        end
    endtask

    task automatic test_reset();
        logic [AW-1:0] qa [3];
        qa[0] = 8'd0; qa[1] = 8'd128; qa[2] = 8'd255;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) poke(qa[i], $urandom() | 32'h1);
        @(negedge clk);
        s_upd_valid = 1'b1; s_upd_addr = 8'd9; s_upd_delta = 16'h1234;
        s_rd_valid = 1'b1; s_rd_addr = 8'd9;
        #1;
        checks++;
        if ({s_upd_ready, s_rd_ready, m_rd_valid, m_rd_data, init_done, ram_en1, ram_addr1,
             ram_en2, ram_we2, ram_addr2, ram_din2} !== '0) begin
            errors++;
            $display("FAIL reset outputs: upd_rdy=%0b rd_rdy=%0b mrv=%0b mrd=%h init=%0b en1=%0b a1=%0d en2=%0b we2=%0b a2=%0d din2=%h, expected all 0",
                     s_upd_ready, s_rd_ready, m_rd_valid, m_rd_data, init_done, ram_en1, ram_addr1,
                     ram_en2, ram_we2, ram_addr2, ram_din2);
        end
        s_upd_valid = 1'b0; s_rd_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        run_clear_check("clear_after_reset");
        for (int i = 0; i < 4; i++) begin
            if (i < 3) drive(1'b0, '0, '0, 1'b0, 1'b1, qa[i]);
            else idle();
            checks++;
            if (obs_rv !== cur_exp_rv || (cur_exp_rv && obs_rd !== cur_exp_rd) ||
                (cur_exp_rv && obs_rd !== '0)) begin
                errors++;
                $display("FAIL reset query %0d: m_rd_valid/data=%0b/%h, expected %0b/%h",
                         i, obs_rv, obs_rd, cur_exp_rv, cur_exp_rd);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [LW-1:0] ds [3];
        ds[0] = 16'd3; ds[1] = 16'd4; ds[2] = 16'd10;
        for (int i = 0; i < 5; i++) begin
            if (i < 3) drive(1'b1, 8'd5, ds[i], 1'b0, 1'b0, '0);
            else if (i == 3) drive(1'b0, '0, '0, 1'b0, 1'b1, 8'd5);
            else idle();
            if (i < 4) begin
                checks++;
                if (acc_u !== (i < 3) || acc_r !== (i == 3)) begin
                    errors++;
                    $display("FAIL b2b accept %0d: upd=%0b rd=%0b, expected %0b %0b",
                             i, acc_u, acc_r, i < 3, i == 3);
                end
            end
            checks++;
            if (obs_rv !== cur_exp_rv || (cur_exp_rv && obs_rd !== cur_exp_rd)) begin
                errors++;
                $display("FAIL b2b result %0d: m_rd_valid/data=%0b/%h, expected %0b/%h",
                         i, obs_rv, obs_rd, cur_exp_rv, cur_exp_rd);
            end
        end
        checks++;
        if (obs_rd !== 32'd17) begin
            errors++;
            $display("FAIL b2b sum: m_rd_data=%0d, expected 17", obs_rd);
        end
    endtask

    task automatic test_saturation();
        logic [DW-1:0] want [2];
        want[0] = 32'hFFFF_FFFF; want[1] = 32'h0;
        poke(8'd7, 32'hFFFF_0005);
        model_cnt[7] = 32'hFFFF_0005;
        drive(1'b1, 8'd7, 16'hFFFF, 1'b0, 1'b0, '0);
        drive(1'b1, 8'd8, 16'd5,    1'b0, 1'b0, '0);
        drive(1'b1, 8'd8, 16'd7,    1'b1, 1'b0, '0);
        for (int i = 0; i < 3; i++) begin
            if (i < 2) drive(1'b0, '0, '0, 1'b0, 1'b1, AW'(7 + i));
            else idle();
            checks++;
            if (obs_rv !== cur_exp_rv || (cur_exp_rv && obs_rd !== cur_exp_rd)) begin
                errors++;
                $display("FAIL sat result %0d: m_rd_valid/data=%0b/%h, expected %0b/%h",
                         i, obs_rv, obs_rd, cur_exp_rv, cur_exp_rd);
            end
            if (i > 0) begin
                checks++;
                if (obs_rv !== 1'b1 || obs_rd !== want[i-1]) begin
                    errors++;
                    $display("FAIL sat value addr %0d: got %0b/%h, expected 1/%h",
                             6 + i, obs_rv, obs_rd, want[i-1]);
                end
            end
        end
    endtask

    task automatic test_arbitration();
        int nu = 0, nr = 0;
        for (int k = 0; k < 11; k++) begin
            if (k < 10) drive(1'b1, AW'(20 + $urandom_range(0, 3)), LW'($urandom()), 1'($urandom()),
                              1'b1, AW'(20 + $urandom_range(0, 3)));
            else idle();
            if (k < 10) begin
                nu += int'(acc_u);
                nr += int'(acc_r);
                checks++;
                if (acc_u !== (k % 2 == 0) || acc_r !== (k % 2 == 1)) begin
                    errors++;
                    $display("FAIL arb grant %0d: upd=%0b rd=%0b, expected %0b %0b",
                             k, acc_u, acc_r, k % 2 == 0, k % 2 == 1);
                end
            end
            checks++;
            if (obs_rv !== cur_exp_rv || (cur_exp_rv && obs_rd !== cur_exp_rd)) begin
                errors++;
                $display("FAIL arb result %0d: m_rd_valid/data=%0b/%h, expected %0b/%h",
                         k, obs_rv, obs_rd, cur_exp_rv, cur_exp_rd);
            end
        end
        checks++;
        if (nu != 5 || nr != 5) begin
            errors++;
            $display("FAIL arb counts: upd=%0d rd=%0d, expected 5 5", nu, nr);
        end
    endtask

    task automatic test_forward();
        drive(1'b1, 8'd3, 16'd9, 1'b0, 1'b0, '0);
        drive(1'b0, '0, '0, 1'b0, 1'b1, 8'd3);
        checks++;
        if (acc_r !== 1'b1) begin
            errors++;
            $display("FAIL fwd accept: rd accepted=%0b, expected 1", acc_r);
        end
        idle();
        checks++;
        if (obs_rv !== 1'b1 || obs_rd !== 32'd9 || cur_exp_rd !== 32'd9) begin
            errors++;
            $display("FAIL fwd result: m_rd_valid/data=%0b/%0d, expected 1/9", obs_rv, obs_rd);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 401; k++) begin
            logic uv, rv;
            uv = (k < 400) && ($urandom_range(0, 3) != 0);
            rv = (k < 400) && ($urandom_range(0, 2) == 0);
            drive(uv, AW'(32 + $urandom_range(0, 7)),
                  ($urandom_range(0, 3) == 0) ? LW'($urandom()) : LW'($urandom_range(0, 20)),
                  ($urandom_range(0, 2) == 0), rv, AW'(32 + $urandom_range(0, 7)));
            checks++;
            if ((acc_u && acc_r) || (uv && !rv && !acc_u) || (rv && !uv && !acc_r) ||
                (uv && rv && !(acc_u || acc_r))) begin
                errors++;
                $display("FAIL rand grant %0d: uv=%0b rv=%0b acc_u=%0b acc_r=%0b", k, uv, rv, acc_u, acc_r);
            end
            checks++;
            if (obs_rv !== cur_exp_rv || (cur_exp_rv && obs_rd !== cur_exp_rd)) begin
                errors++;
                $display("FAIL rand result %0d: m_rd_valid/data=%0b/%h, expected %0b/%h",
                         k, obs_rv, obs_rd, cur_exp_rv, cur_exp_rd);
            end
        end
        idle();
    endtask

    task automatic test_reset_midstream();
        logic [DW-1:0] pre;
        drive(1'b1, 8'd10, 16'd50, 1'b0, 1'b0, '0);
        @(negedge clk);
        s_upd_valid = 1'b0;
        pre = mem[10];
        checks++;
        if (ram_we2 !== 1'b1 || ram_addr2 !== 8'd10 || ram_din2 !== (pre + 32'd50)) begin
            errors++;
            $display("FAIL midrst stage1: we2=%0b addr2=%0d din2=%0d, expected 1 10 %0d",
                     ram_we2, ram_addr2, ram_din2, pre + 32'd50);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({s_upd_ready, s_rd_ready, m_rd_valid, m_rd_data, init_done, ram_en1, ram_addr1,
             ram_en2, ram_we2, ram_addr2, ram_din2} !== '0) begin
            errors++;
            $display("FAIL midrst outputs: mrv=%0b init=%0b en1=%0b en2=%0b we2=%0b a2=%0d din2=%h, expected all 0",
                     m_rd_valid, init_done, ram_en1, ram_en2, ram_we2, ram_addr2, ram_din2);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (mem[10] !== pre) begin
            errors++;
            $display("FAIL midrst no write: ram[10]=%0d, expected %0d", mem[10], pre);
        end
        rst = 1'b0;
        model_clear();
        run_clear_check("clear_after_midrst");
        drive(1'b0, '0, '0, 1'b0, 1'b1, 8'd10);
        idle();
        checks++;
        if (obs_rv !== 1'b1 || obs_rd !== '0 || cur_exp_rd !== '0) begin
            errors++;
            $display("FAIL midrst query: m_rd_valid/data=%0b/%0d, expected 1/0", obs_rv, obs_rd);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        test_reset();
        test_back_to_back();
        test_saturation();
        test_arbitration();
        test_forward();
        test_random();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
